// File: rtl/ddr_sim_pkg.sv
// ddr_sim_pkg: shared constants and configuration checks for the DDR3 Avalon-MM simulation model.
package ddr_sim_pkg;
   localparam int MAX_RD_LATENCY = 8;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 8;
   function automatic bit be_width_ok(input int data_w, input int be_w);
      return (data_w % 8 == 0) && (be_w == data_w / 8);
   endfunction
endpackage

// File: rtl/ddr_rd_pipe.sv
// ddr_rd_pipe: fixed-latency read return shift register; reset flushes valid bits only.
module ddr_rd_pipe import ddr_sim_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int RD_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);
   logic [RD_LATENCY-1:0] vld;
   logic [DATA_W-1:0] dat [RD_LATENCY];
   always_ff @(posedge clk) begin
      if (rst) vld <= '0;
      else begin
         vld[0] <= in_valid;
         for (int i = 1; i < RD_LATENCY; i++) vld[i] <= vld[i-1];
      end
   end
   always_ff @(posedge clk) begin
      dat[0] <= in_data;
      for (int i = 1; i < RD_LATENCY; i++) dat[i] <= dat[i-1];
   end
   assign out_valid = vld[RD_LATENCY-1];
   assign out_data = dat[RD_LATENCY-1];
endmodule

// File: rtl/ddr3_mem_model.sv
// ddr3_mem_model: cycle-accurate Avalon-MM DDR3 slave model with byte enables, read latency,
// stall injection, collision flag and transaction counters.
module ddr3_mem_model import ddr_sim_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int RD_LATENCY = 2,
   parameter int STALL_ADDR = 25,
   parameter int STALL_CYCLES = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              ddr_addr,
   input  logic                     ddr_read,
   input  logic                     ddr_write,
   input  logic signed [DATA_W-1:0] ddr_writedata,
   input  logic [DATA_W/8-1:0]      ddr_byteenable,
   output logic signed [DATA_W-1:0] ddr_readdata,
   output logic                     ddr_readdatavalid,
   output logic                     ddr_waitrequest,
   output logic                     err_collision,
   output logic [31:0]              rd_count,
   output logic [31:0]              wr_count
);
   localparam int BE_W = DATA_W / 8;
   if (!be_width_ok(DATA_W, BE_W) || RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_cfg
      $error("ddr3_mem_model: illegal DATA_W or RD_LATENCY");
   end
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [ADDR_W-1:0] a;
   logic [31:0] stall_cnt;
   logic read_acc, write_acc, pv;
   logic [DATA_W-1:0] pd;
   logic unused_addr_bits;
   assign a = ddr_addr[ADDR_W-1:0];
   assign unused_addr_bits = &{1'b0, ddr_addr[31:ADDR_W]};
   assign ddr_waitrequest = (stall_cnt != 0) | (ddr_read & ddr_write);
   assign read_acc = ddr_read & ~ddr_write & ~ddr_waitrequest;
   assign write_acc = ddr_write & ~ddr_read & ~ddr_waitrequest;
   always_ff @(posedge clk) begin
      if (write_acc)
         for (int i = 0; i < BE_W; i++)
            if (ddr_byteenable[i]) mem[a][8*i +: 8] <= ddr_writedata[8*i +: 8];
   end
   // Reads never coincide with an accepted write, so sampling here sees every committed write.
   ddr_rd_pipe #(.DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY)) u_pipe (
      .clk(clk),
      .rst(rst),
      .in_valid(read_acc),
      .in_data(mem[a]),
      .out_valid(pv),
      .out_data(pd)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         err_collision <= 1'b0;
         rd_count <= '0;
         wr_count <= '0;
         ddr_readdata <= '0;
         ddr_readdatavalid <= 1'b0;
      end else begin
         stall_cnt <= (STALL_CYCLES > 0 && write_acc && a == ADDR_W'(STALL_ADDR)) ? 32'(STALL_CYCLES)
                    : stall_cnt - 32'(stall_cnt != 0);
         err_collision <= err_collision | (ddr_read & ddr_write);
         rd_count <= rd_count + 32'(read_acc);
         wr_count <= wr_count + 32'(write_acc);
         ddr_readdatavalid <= pv;
         if (pv) ddr_readdata <= pd;
      end
   end
endmodule

// File: tb/tb_ddr3_mem_model.sv
// tb_ddr3_mem_model: directed and randomized checks of ddr3_mem_model against a
// transaction-level model (array memory, queue of due read returns, stall countdown).
module tb_ddr3_mem_model;
   localparam int L = 2, SA = 25, SC = 10;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, rd, wr, rvalid, wreq, err;
   logic [31:0] addr, rdc, wrc;
   logic [15:0] wdata, rdata;
   logic [1:0] be;
   ddr3_mem_model dut (
      .clk(clk), .rst(rst), .ddr_addr(addr), .ddr_read(rd), .ddr_write(wr),
      .ddr_writedata(wdata), .ddr_byteenable(be), .ddr_readdata(rdata),
      .ddr_readdatavalid(rvalid), .ddr_waitrequest(wreq), .err_collision(err),
      .rd_count(rdc), .wr_count(wrc)
   );
   int passes = 0, total = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passes++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask
   typedef struct { int due; logic [15:0] d; } rd_t;
   rd_t q[$];
   logic [15:0] m_mem [256];
   logic [15:0] m_last = '0;
   int m_stall = 0, cyc = 0, acc_cyc = 0, v_cyc = 0;
   bit m_err = 0, acc = 0;
   int unsigned m_rd = 0, m_wr = 0;
   task automatic tick(input bit r, input bit w, input logic [31:0] a, input logic [15:0] d,
                       input logic [1:0] b, input bit rs);
      int idx;
      bit wt, ev;
      rst = rs; rd = r; wr = w; addr = a; wdata = d; be = b;
      #1;
      wt = (m_stall > 0) || (r && w);
      if (!rs) chk("waitrequest", wreq, wt);
      @(posedge clk);
      cyc++;
      idx = int'(a[7:0]);
      acc = 0;
      if (rs) begin
         q.delete(); m_stall = 0; m_err = 0; m_rd = 0; m_wr = 0; m_last = '0;
      end else begin
         if (r && w) m_err = 1;
         if (m_stall > 0) m_stall--;
         if (!wt && r && !w) begin
            q.push_back('{cyc + L, m_mem[idx]});
            m_rd++; acc = 1; acc_cyc = cyc;
         end
         if (!wt && w && !r) begin
            if (b[0]) m_mem[idx][7:0] = d[7:0];
            if (b[1]) m_mem[idx][15:8] = d[15:8];
            m_wr++; acc = 1;
            if (idx == SA) m_stall = SC;
         end
      end
      @(negedge clk);
      ev = (q.size() > 0) && (q[0].due == cyc);
      if (ev) begin
         m_last = q[0].d;
         void'(q.pop_front());
      end
      if (rvalid) v_cyc = cyc;
      chk("readdatavalid", rvalid, ev);
      chk("readdata", rdata, m_last);
      chk("rd_count", rdc, m_rd);
      chk("wr_count", wrc, m_wr);
      chk("err_collision", err, m_err);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
   endtask
   task automatic do_write(input logic [31:0] a, input logic [15:0] d, input logic [1:0] b);
      int n = 0;
      do begin tick(0, 1, a, d, b, 0); n++; end while (!acc && n < 100);
      if (!acc) chk("write_timeout", 0, 1);
   endtask
   task automatic do_read(input logic [31:0] a, output int n);
      n = 0;
      do begin tick(1, 0, a, 0, 0, 0); n++; end while (!acc && n < 100);
      if (!acc) chk("read_timeout", 0, 1);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      int n, k, w0;
      tick(0, 0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 0, 1);
      chk("reset_wait", wreq, 0);
      do_write(5, 16'h1234, 2'b11);
      do_read(5, n);
      idle(3);
      chk("t1_latency", v_cyc - acc_cyc, L);
      chk("t1_data", rdata, 16'h1234);
      chk("t1_counts", {wrc[15:0], rdc[15:0]}, 32'h0001_0001);
      do_write(5, 16'hAB00, 2'b10);
      do_read(5, n);
      idle(3);
      chk("t2_data", rdata, 16'hAB34);
      do_write(7, 16'h0777, 2'b11);
      do_read(5, n);
      do_write(SA, 16'h5555, 2'b11);
      do_read(7, n);
      chk("t3_held_read", n, SC + 1);
      idle(3);
      chk("t3_data", rdata, 16'h0777);
      do_write(3, 16'h0033, 2'b11);
      w0 = int'(wrc);
      tick(1, 1, 3, 16'hFFFF, 2'b11, 0);
      idle(20);
      chk("t4_err", err, 1);
      chk("t4_wr_unchanged", wrc, w0);
      do_read(3, n);
      idle(3);
      chk("t4_mem_unchanged", rdata, 16'h0033);
      for (int i = 0; i < 4; i++) do_write(i, 16'(10 + i), 2'b11);
      for (int i = 0; i < 4; i++) do_read(i, n);
      idle(3);
      chk("t5_last", rdata, 13);
      do_write(256, 16'd7, 2'b11);
      do_read(0, n);
      idle(3);
      chk("t5_alias", rdata, 7);
      do_read(5, n);
      tick(0, 0, 0, 0, 0, 1);
      idle(4);
      do_write(SA, 16'h0001, 2'b11);
      idle(2);
      tick(0, 0, 0, 0, 0, 1);
      chk("t6_wait", wreq, 0);
      chk("t6_err", err, 0);
      idle(2);
      for (int i = 0; i < 256; i++) do_write(i, 16'($urandom), 2'b11);
      for (int i = 0; i < 400; i++) begin
         k = int'($urandom_range(0, 19));
         if (k < 9) do_write($urandom_range(0, 511), 16'($urandom), 2'($urandom_range(0, 3)));
         else if (k < 18) do_read($urandom_range(0, 511), n);
         else if (k == 18) tick(1, 1, $urandom_range(0, 511), 16'($urandom), 2'b11, 0);
         else idle(1);
      end
      idle(5);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule

// File: doc/ddr3_mem_model.md
Name: ddr3_mem_model

Overview:
- Parametrised, cycle-accurate behavioural model of the DDR3 Avalon-MM slave. It stands in for the external memory controller in LPC filter-core testbenches.
- Generalises the earlier fixed 16-bit/256-word model with configurable data and address width, a fixed read latency pipeline, and programmable stall injection.
- Adds byte enables, a collision error flag and transaction counters.
- Simulation-only: not synthesised. The RTL stays synthesisable-style (no event controls inside always blocks) so it runs under any simulator.

Parameters:
- DATA_W, 16, data bus width in bits; must be a multiple of 8.
- ADDR_W, 8, number of word-address bits decoded; depth = 2**ADDR_W words.
- RD_LATENCY, 2, cycles from read acceptance to ddr_readdatavalid; legal range 1..8.
- STALL_ADDR, 25, a write accepted to this word address triggers a stall burst.
- STALL_CYCLES, 10, length of the stall burst in cycles; 0 disables stall injection.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- ddr_addr  input  32  word address; only bits [ADDR_W-1:0] are decoded.
- ddr_read  input  1  read request.
- ddr_write  input  1  write request.
- ddr_writedata  input  DATA_W  signed write data.
- ddr_byteenable  input  DATA_W/8  per-byte write enable.
- ddr_readdata  output  DATA_W  signed read data.
- ddr_readdatavalid  output  1  read data qualifier.
- ddr_waitrequest  output  1  slave not accepting the request this cycle.
- err_collision  output  1  sticky; set when read and write are asserted together.
- rd_count  output  32  accepted reads since reset.
- wr_count  output  32  accepted writes since reset.

Behaviour:
- Reset (rst high at a clk edge):
  - ddr_readdata=0, ddr_readdatavalid=0, err_collision=0, rd_count=0, wr_count=0.
  - Stall counter cleared; read pipeline flushed; no in-flight read survives reset.
  - Memory array is NOT cleared.
- Waitrequest: ddr_waitrequest = (stall_cnt != 0) | (ddr_read & ddr_write).
  - The collision term is combinational.
  - The stall term comes from a register.
- Acceptance:
  - read_acc = ddr_read & ~ddr_write & ~ddr_waitrequest.
  - write_acc = ddr_write & ~ddr_read & ~ddr_waitrequest.
  - The master holds its request until accepted.
- Write:
  - On write_acc, mem[addr] is updated for each byte lane i where ddr_byteenable[i]=1.
  - Disabled lanes keep their old value.
  - wr_count increments by 1.
- Read:
  - On read_acc, mem[addr] is sampled into pipeline stage 0 at that edge.
  - ddr_readdata and ddr_readdatavalid=1 appear exactly RD_LATENCY cycles after the accepting edge.
  - ddr_readdatavalid is a one-cycle pulse per read; back-to-back reads give back-to-back valids.
  - rd_count increments on acceptance.
  - ddr_readdata holds its last value when valid is low.
- Read-after-write: a read accepted on the cycle after a write to the same address returns the new data. Reads sample the array after the write commits.
- Stall injection:
  - Applies when STALL_CYCLES>0 and write_acc targets addr==STALL_ADDR.
  - stall_cnt loads STALL_CYCLES, so waitrequest is high for exactly STALL_CYCLES cycles starting the next cycle.
  - stall_cnt decrements to 0 and then holds.
  - A stall trigger while stall_cnt!=0 cannot occur, because no write is accepted during a stall.
- Reads already in the pipeline complete during a stall; the stall blocks new commands only.
- Collision:
  - read & write asserted together: neither is accepted and waitrequest is high.
  - err_collision sets and stays set until rst.
- Address wrap: bits above ADDR_W-1 are ignored, so address 2**ADDR_W aliases to 0.
- Counters wrap modulo 2**32.
- Reset mid-stall: stall_cnt=0, and waitrequest drops in the first cycle after the reset edge unless a collision is present.

Decomposition:
- Shared package ddr_sim_pkg:
  - localparam MAX_RD_LATENCY=8.
  - Default DATA_W/ADDR_W constants shared with the LPC core.
  - Function checking the byte-enable mask width.
- One natural sub-module: ddr_rd_pipe.
  - Parametrised RD_LATENCY shift register carrying {valid, data}.
  - Synchronous rst clears only the valid bits.

Test Plan:
- Write 16'h1234 to addr 5 (be=2'b11), then read addr 5 -> readdatavalid pulses exactly 2 cycles after read acceptance with readdata=16'h1234; wr_count=1, rd_count=1.
- Write 16'hAB00 with be=2'b10 over existing 16'h1234 at addr 5 -> a subsequent read returns 16'hAB34.
- Write to addr 25 -> waitrequest high for 10 consecutive cycles starting the next cycle; a read held during the stall is accepted on cycle 11; an earlier in-flight read still returns on time.
- Assert read and write together at addr 3 -> waitrequest=1 in that cycle, no memory change, counters unchanged, err_collision=1 and still 1 after 20 idle cycles.
- Issue 4 back-to-back reads of addrs 0..3 (preloaded 10,11,12,13) -> 4 consecutive valid cycles with data 10,11,12,13; then write addr 256 value 7 and read addr 0 -> returns 7 (alias).
- Assert rst one cycle after a read is accepted and during a stall -> no readdatavalid ever appears for that read; waitrequest=0, counters=0 and err_collision=0 after the reset edge.
